// File: rtl/fighter_ctrl.sv
// Per-player action controller: buttons plus hit/health status in,
// registered one-hot action code and request/feedback strobes out.
module fighter_ctrl #(
   parameter int JUMP_CYCLES     = 50_000_000,
   parameter int PUNCH_CYCLES    = 12_500_000,
   parameter int COOLDOWN_CYCLES = 25_000_000,
   parameter int HITSTUN_CYCLES  = 20_000_000,
   parameter int CNT_W           = 27,
   parameter bit START_DIR       = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left_btn,
   input  logic       right_btn,
   input  logic       down_btn,
   input  logic       shield_btn,
   input  logic       up_btn,
   input  logic       attack_btn,
   input  logic       hit,
   input  logic [7:0] health,
   input  logic [7:0] shield,
   output logic [8:0] action,
   output logic       attack_request,
   output logic       jump_request,
   output logic       descending,
   output logic       blocked
);

   typedef enum logic [7:0] {
      WALKING   = 8'h01,
      CROUCHING = 8'h02,
      SHIELDING = 8'h04,
      JUMPING   = 8'h08,
      PUNCHING  = 8'h10,
      STANDING  = 8'h20,
      HITSTUN   = 8'h40,
      KO        = 8'h80
   } state_t;

   localparam logic [CNT_W-1:0] JUMP_LD  = CNT_W'(JUMP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PUNCH_LD = CNT_W'(PUNCH_CYCLES - 1);
   localparam logic [CNT_W-1:0] CD_LD    = CNT_W'(COOLDOWN_CYCLES - 1);
   localparam logic [CNT_W-1:0] HIT_LD   = CNT_W'(HITSTUN_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF     = CNT_W'(JUMP_CYCLES / 2);

   state_t           state;
   logic             facing;
   logic [CNT_W-1:0] state_cnt;
   logic [CNT_W-1:0] cooldown;
   logic             up_prev;
   logic             atk_prev;
   logic             atk_buf;
   logic             up_edge;
   logic             atk_edge;
   logic             cd_zero;

   assign up_edge  = up_btn & ~up_prev;
   assign atk_edge = attack_btn & ~atk_prev;
   assign cd_zero  = (cooldown == '0);
   assign action   = {facing, state};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= STANDING;
         facing         <= START_DIR;
         state_cnt      <= '0;
         cooldown       <= '0;
         up_prev        <= 1'b1;
         atk_prev       <= 1'b1;
         atk_buf        <= 1'b0;
         attack_request <= 1'b0;
         jump_request   <= 1'b0;
         descending     <= 1'b0;
         blocked        <= 1'b0;
      end else begin
         up_prev        <= up_btn;
         atk_prev       <= attack_btn;
         attack_request <= 1'b0;
         jump_request   <= 1'b0;
         descending     <= 1'b0;
         blocked        <= 1'b0;
         if (!cd_zero) cooldown <= cooldown - 1'b1;
         unique case (state)
            STANDING, WALKING, CROUCHING, SHIELDING: begin
               if (right_btn) facing <= 1'b0;
               else if (left_btn) facing <= 1'b1;
               if (health == 8'd0) begin
                  state <= KO;
               end else if (hit && state == SHIELDING) begin
                  blocked <= 1'b1;
               end else if (hit) begin
                  state     <= HITSTUN;
                  state_cnt <= HIT_LD;
               end else if (up_edge) begin
                  // a simultaneous attack edge is dropped, not buffered
                  state        <= JUMPING;
                  state_cnt    <= JUMP_LD;
                  jump_request <= 1'b1;
                  atk_buf      <= 1'b0;
               end else if (atk_edge && cd_zero) begin
                  state          <= PUNCHING;
                  state_cnt      <= PUNCH_LD;
                  cooldown       <= CD_LD;
                  attack_request <= 1'b1;
               end else if (shield_btn && shield != 8'd0) begin
                  state <= SHIELDING;
               end else if (down_btn) begin
                  state <= CROUCHING;
               end else if (left_btn || right_btn) begin
                  state <= WALKING;
               end else begin
                  state <= STANDING;
               end
            end
            JUMPING, PUNCHING, HITSTUN: begin
               if (health == 8'd0) begin
                  state <= KO;
               end else if (hit) begin
                  state     <= HITSTUN;
                  state_cnt <= HIT_LD;
                  atk_buf   <= 1'b0;
               end else if (state_cnt != '0) begin
                  state_cnt <= state_cnt - 1'b1;
                  if (state == JUMPING) begin
                     descending <= (state_cnt - 1'b1) < HALF;
                     if (atk_edge) atk_buf <= 1'b1;
                  end
               end else if (state == JUMPING && atk_buf && cd_zero) begin
                  state          <= PUNCHING;
                  state_cnt      <= PUNCH_LD;
                  cooldown       <= CD_LD;
                  attack_request <= 1'b1;
                  atk_buf        <= 1'b0;
               end else begin
                  state   <= STANDING;
                  atk_buf <= 1'b0;
               end
            end
            KO: begin
            end
            default: state <= STANDING;
         endcase
      end
   end

endmodule

// File: tb/tb_fighter_ctrl.sv
// Directed bench for fighter_ctrl with short, cycle-countable durations.
module tb_fighter_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       left_btn, right_btn, down_btn, shield_btn;
   logic       up_btn, attack_btn, hit;
   logic [7:0] health, shield;
   logic [8:0] action;
   logic       attack_request, jump_request, descending, blocked;

   int tests  = 0;
   int failed = 0;

   fighter_ctrl #(
      .JUMP_CYCLES    (8),
      .PUNCH_CYCLES   (3),
      .COOLDOWN_CYCLES(14),
      .HITSTUN_CYCLES (4),
      .CNT_W          (5),
      .START_DIR      (1'b1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .left_btn      (left_btn),
      .right_btn     (right_btn),
      .down_btn      (down_btn),
      .shield_btn    (shield_btn),
      .up_btn        (up_btn),
      .attack_btn    (attack_btn),
      .hit           (hit),
      .health        (health),
      .shield        (shield),
      .action        (action),
      .attack_request(attack_request),
      .jump_request  (jump_request),
      .descending    (descending),
      .blocked       (blocked)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [8:0] obs,
                        input logic [8:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0;
      left_btn = 0; right_btn = 0; down_btn = 0; shield_btn = 0;
      up_btn = 0; attack_btn = 1; hit = 0;
      health = 8'd100; shield = 8'd0;
      #12;
      check("rst_action", action, 9'h120);
      check("rst_atkreq", {8'd0, attack_request}, 9'd0);
      check("rst_jmpreq", {8'd0, jump_request}, 9'd0);
      check("rst_desc", {8'd0, descending}, 9'd0);
      tick();
      reset = 1'b1;

      // attack held through reset release gives no edge
      tick();
      check("held_action", action, 9'h120);
      check("held_req", {8'd0, attack_request}, 9'd0);
      tick();
      check("held_req2", {8'd0, attack_request}, 9'd0);
      attack_btn = 0;
      tick();
      attack_btn = 1;
      tick();
      check("punch1_action", action, 9'h110);
      check("punch1_req", {8'd0, attack_request}, 9'd1);
      attack_btn = 0;
      tick();
      check("punch1_c2", action, 9'h110);
      check("punch1_req_once", {8'd0, attack_request}, 9'd0);
      tick();
      check("punch1_c3", action, 9'h110);
      tick();
      check("punch1_end", action, 9'h120);
      attack_btn = 1;
      tick();
      check("cd_t4_action", action, 9'h120);
      check("cd_t4_req", {8'd0, attack_request}, 9'd0);
      attack_btn = 0;
      repeat (7) tick();
      attack_btn = 1;
      tick();
      check("cd_t12_req", {8'd0, attack_request}, 9'd0);
      attack_btn = 0;
      tick();
      attack_btn = 1;
      tick();
      check("cd_t14_action", action, 9'h110);
      check("cd_t14_req", {8'd0, attack_request}, 9'd1);
      attack_btn = 0;
      repeat (3) tick();
      check("punch2_end", action, 9'h120);

      // grounded moves and facing
      right_btn = 1;
      tick();
      check("walk_right", action, 9'h001);
      right_btn = 0;
      down_btn  = 1;
      tick();
      check("crouch", action, 9'h002);
      down_btn = 0;
      tick();
      check("stand_right", action, 9'h020);

      // jump timing and frozen facing
      up_btn = 1;
      tick();
      check("jump_action", action, 9'h008);
      check("jump_req", {8'd0, jump_request}, 9'd1);
      check("jump_desc0", {8'd0, descending}, 9'd0);
      up_btn   = 0;
      left_btn = 1;
      for (int k = 1; k < 8; k++) begin
         tick();
         check($sformatf("jump_c%0d", k), action, 9'h008);
         check($sformatf("jump_req_c%0d", k), {8'd0, jump_request}, 9'd0);
         check($sformatf("jump_desc_c%0d", k), {8'd0, descending},
               (k >= 4) ? 9'd1 : 9'd0);
      end
      tick();
      check("jump_land", action, 9'h020);
      check("land_desc", {8'd0, descending}, 9'd0);
      tick();
      check("walk_left", action, 9'h101);
      left_btn = 0;
      tick();
      check("stand_left", action, 9'h120);

      // buffered attack, cooldown clear at landing
      repeat (16) tick();
      up_btn = 1;
      tick();
      check("bj_jump", action, 9'h108);
      up_btn = 0;
      repeat (2) tick();
      attack_btn = 1;
      tick();
      check("bj_no_punch", action, 9'h108);
      check("bj_no_req", {8'd0, attack_request}, 9'd0);
      attack_btn = 0;
      repeat (4) tick();
      check("bj_c7", action, 9'h108);
      tick();
      check("bj_land_punch", action, 9'h110);
      check("bj_land_req", {8'd0, attack_request}, 9'd1);
      repeat (2) tick();
      check("bj_punch_c3", action, 9'h110);
      tick();
      check("bj_punch_end", action, 9'h120);

      // buffered attack with cooldown still running at landing
      up_btn = 1;
      tick();
      check("bj2_jump", action, 9'h108);
      up_btn = 0;
      repeat (2) tick();
      attack_btn = 1;
      tick();
      attack_btn = 0;
      repeat (4) tick();
      tick();
      check("bj2_land", action, 9'h120);
      check("bj2_land_req", {8'd0, attack_request}, 9'd0);

      // shield blocking and hitstun
      shield     = 8'd5;
      shield_btn = 1;
      tick();
      check("shield", action, 9'h104);
      hit = 1;
      tick();
      check("block_action", action, 9'h104);
      check("block_pulse", {8'd0, blocked}, 9'd1);
      hit = 0;
      tick();
      check("block_once", {8'd0, blocked}, 9'd0);
      check("shield_hold", action, 9'h104);
      shield = 8'd0;
      tick();
      check("shield_empty", action, 9'h120);
      hit = 1;
      tick();
      check("stun_h0", action, 9'h140);
      check("stun_noblock", {8'd0, blocked}, 9'd0);
      hit = 0;
      tick();
      check("stun_h1", action, 9'h140);
      hit = 1;
      tick();
      check("stun_h2", action, 9'h140);
      hit = 0;
      tick();
      tick();
      check("stun_h4_ext", action, 9'h140);
      tick();
      check("stun_h5_ext", action, 9'h140);
      tick();
      check("stun_exit", action, 9'h120);
      shield_btn = 0;

      // KO during punch with simultaneous hit
      attack_btn = 1;
      tick();
      check("ko_punch", action, 9'h110);
      attack_btn = 0;
      health = 8'd0;
      hit    = 1;
      tick();
      check("ko_enter", action, 9'h180);
      hit = 0;
      for (int i = 0; i < 4; i++) begin
         up_btn     = i[0];
         attack_btn = i[0];
         left_btn   = ~i[0];
         right_btn  = i[0];
         health     = 8'd50;
         tick();
         check($sformatf("ko_hold%0d", i), action, 9'h180);
         check($sformatf("ko_req%0d", i),
               {7'd0, attack_request, jump_request}, 9'd0);
      end

      // asynchronous reset, then simultaneous up and attack edges
      reset = 0;
      up_btn = 0; attack_btn = 0; left_btn = 0; right_btn = 0;
      #2;
      check("async_rst", action, 9'h120);
      tick();
      reset = 1;
      tick();
      up_btn     = 1;
      attack_btn = 1;
      tick();
      check("both_jump", action, 9'h108);
      check("both_jreq", {8'd0, jump_request}, 9'd1);
      check("both_areq", {8'd0, attack_request}, 9'd0);
      up_btn     = 0;
      attack_btn = 0;
      repeat (7) tick();
      tick();
      check("both_land", action, 9'h120);
      check("both_land_req", {8'd0, attack_request}, 9'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
